// File: rtl/rv_if_ctrl_pkg.sv
// Shared types for the instruction-fetch controller, plus the flop macro
// every register in this slice is built from.
`ifndef RV_DFF_MACROS_SV
`define RV_DFF_MACROS_SV
`define RV_DFF_R(q, d, rst_val, clk, rst) \
   always_ff @(posedge clk) begin \
      if (rst) q <= rst_val; \
      else     q <= d; \
   end
`endif

package rv_if_ctrl_pkg;

   typedef struct packed {
      logic ready_Q100H;
      logic ready_Q101H;
      logic sel_next_pc_alu_out_Q102H;
   } t_if_ctrl;

   typedef enum logic [1:0] {
      IF_START = 2'd0,
      IF_RUN   = 2'd1,
      IF_STALL = 2'd2,
      IF_FLUSH = 2'd3
   } t_if_ctrl_state;

   localparam int unsigned START_CNT_W = 4;

   function automatic logic fetch_active(input t_if_ctrl_state st);
      return (st != IF_START);
   endfunction

endpackage

// File: rtl/rv_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module rv_sat_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_r;
   logic [W-1:0] cnt_nxt_s;

   // next count: step by one unless already saturated
   always_comb begin
      cnt_nxt_s = cnt_r;
      if (inc && (cnt_r != {W{1'b1}})) begin
         cnt_nxt_s = cnt_r + W'(1'b1);
      end else begin
         cnt_nxt_s = cnt_r;
      end
   end

   // count register
   `RV_DFF_R(cnt_r, cnt_nxt_s, {W{1'b0}}, clk, clr)

   assign cnt = cnt_r;

endmodule

// File: rtl/rv_if_ctrl.sv
// Fetch-stage controller: start-up hold-off, stall/redirect sequencing,
// Q101H validity tracking and stall/flush performance counters.
module rv_if_ctrl
   import rv_if_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W     = 16,
   parameter int unsigned START_CYC = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             redirect_Q102H,
   input  logic             hold_Q102H,
   input  logic             imem_ready,
   output t_if_ctrl         ctrl,
   output logic             flush_Q101H,
   output logic             flush_Q102H,
   output logic             valid_Q101H,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [START_CNT_W-1:0] START_LAST = START_CNT_W'(START_CYC - 1);

   t_if_ctrl_state         state_r, state_nxt_s;
   logic [START_CNT_W-1:0] start_cnt_r, start_cnt_nxt_s;
   logic                   valid_r, valid_nxt_s;
   logic                   active_s, sel_s, ready_s, stall_inc_s;
   logic [CNT_W-1:0]       stall_cnt_s, flush_cnt_s;

   // redirect wins over hold/imem_ready; everything is forced low under reset
   always_comb begin
      active_s    = ~rst & fetch_active(state_r);
      sel_s       = active_s & redirect_Q102H;
      ready_s     = sel_s | (active_s & ~hold_Q102H & imem_ready);
      stall_inc_s = active_s & ((state_r == IF_RUN) || (state_r == IF_STALL))
                    & ~ready_s & ~redirect_Q102H;
      if (ready_s) begin
         valid_nxt_s = active_s & ~sel_s;
      end else begin
         valid_nxt_s = valid_r;
      end
   end

   // state sequencing; redirects are not honoured until START has elapsed
   always_comb begin
      state_nxt_s     = state_r;
      start_cnt_nxt_s = start_cnt_r;
      case (state_r)
         IF_START: begin
            if (start_cnt_r == START_LAST) begin
               state_nxt_s = IF_RUN;
            end else begin
               start_cnt_nxt_s = start_cnt_r + 4'd1;
            end
         end
         IF_RUN: begin
            if (redirect_Q102H)                      state_nxt_s = IF_FLUSH;
            else if (hold_Q102H || !imem_ready)      state_nxt_s = IF_STALL;
            else                                     state_nxt_s = IF_RUN;
         end
         IF_STALL: begin
            if (redirect_Q102H)                      state_nxt_s = IF_FLUSH;
            else if (!hold_Q102H && imem_ready)      state_nxt_s = IF_RUN;
            else                                     state_nxt_s = IF_STALL;
         end
         IF_FLUSH: begin
            if (redirect_Q102H)                      state_nxt_s = IF_FLUSH;
            else                                     state_nxt_s = IF_RUN;
         end
         default: begin
            state_nxt_s     = IF_START;
            start_cnt_nxt_s = 4'd0;
         end
      endcase
   end

   // FSM state register
   `RV_DFF_R(state_r, state_nxt_s, IF_START, clk, rst)

   // start-up hold-off counter
   `RV_DFF_R(start_cnt_r, start_cnt_nxt_s, 4'd0, clk, rst)

   // Q101H validity register
   `RV_DFF_R(valid_r, valid_nxt_s, 1'b0, clk, rst)

   rv_sat_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .clr (rst),
      .inc (stall_inc_s),
      .cnt (stall_cnt_s)
   );

   rv_sat_cnt #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .clr (rst),
      .inc (sel_s),
      .cnt (flush_cnt_s)
   );

   assign ctrl.ready_Q100H               = ready_s;
   assign ctrl.ready_Q101H               = ready_s;
   assign ctrl.sel_next_pc_alu_out_Q102H = sel_s;
   assign flush_Q101H                    = sel_s;
   assign flush_Q102H                    = sel_s;
   assign valid_Q101H                    = ~rst & valid_r;
   assign stall_cnt                      = stall_cnt_s & {CNT_W{~rst}};
   assign flush_cnt                      = flush_cnt_s & {CNT_W{~rst}};

endmodule

// File: tb/tb_rv_if_ctrl.sv
// Bench for rv_if_ctrl: directed vector table, corner sequences, and
// random traffic against a cycle-count/event based reference model.
module tb_rv_if_ctrl;
   import rv_if_ctrl_pkg::*;

   localparam int CNT_W     = 4;
   localparam int START_CYC = 1;
   localparam int CMAX      = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             redirect_Q102H = 1'b0;
   logic             hold_Q102H = 1'b0;
   logic             imem_ready = 1'b1;
   t_if_ctrl         ctrl;
   logic             flush_Q101H, flush_Q102H, valid_Q101H;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int n_checks = 0;
   int n_err    = 0;

   rv_if_ctrl #(.CNT_W(CNT_W), .START_CYC(START_CYC)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_Q102H (redirect_Q102H),
      .hold_Q102H     (hold_Q102H),
      .imem_ready     (imem_ready),
      .ctrl           (ctrl),
      .flush_Q101H    (flush_Q101H),
      .flush_Q102H    (flush_Q102H),
      .valid_Q101H    (valid_Q101H),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: cycles since reset, whether the previous cycle took a
   // redirect, and plain integer counters.
   int   m_cyc = 0;
   bit   m_prev_sel = 1'b0;
   bit   m_valid = 1'b0;
   int   m_stall = 0;
   int   m_fcnt = 0;
   bit   m_act, m_sel, m_ready;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Apply inputs in the low phase and compare every output against the model.
   task automatic drive(input logic r, input logic rd, input logic h, input logic im);
      @(negedge clk);
      rst = r; redirect_Q102H = rd; hold_Q102H = h; imem_ready = im;
      #1;
      m_act   = !r && (m_cyc >= START_CYC);
      m_sel   = m_act && rd;
      m_ready = m_sel || (m_act && !h && im);
      chk("model_ready_Q100H", int'(ctrl.ready_Q100H), int'(m_ready));
      chk("model_ready_Q101H", int'(ctrl.ready_Q101H), int'(m_ready));
      chk("model_sel",         int'(ctrl.sel_next_pc_alu_out_Q102H), int'(m_sel));
      chk("model_flush_Q101H", int'(flush_Q101H), int'(m_sel));
      chk("model_flush_Q102H", int'(flush_Q102H), int'(m_sel));
      chk("model_valid",       int'(valid_Q101H), r ? 0 : int'(m_valid));
      chk("model_stall_cnt",   int'(stall_cnt),   r ? 0 : m_stall);
      chk("model_flush_cnt",   int'(flush_cnt),   r ? 0 : m_fcnt);
   endtask

   // Advance through the rising edge and update the model.
   task automatic tick();
      @(posedge clk);
      if (rst) begin
         m_cyc = 0; m_prev_sel = 1'b0; m_valid = 1'b0; m_stall = 0; m_fcnt = 0;
      end else begin
         if (m_ready) m_valid = m_act && !m_sel;
         if (m_act && !m_prev_sel && !m_ready && !redirect_Q102H && m_stall < CMAX)
            m_stall++;
         if (m_sel && m_fcnt < CMAX) m_fcnt++;
         m_prev_sel = m_sel;
         if (m_cyc < 1000) m_cyc++;
      end
   endtask

   task automatic cyc(input logic r, input logic rd, input logic h, input logic im);
      drive(r, rd, h, im);
      tick();
   endtask

   typedef struct {
      logic rst, rd, h, im;
      logic rdy, sel, vld;
      int   st, fc;
   } vec_t;

   function automatic vec_t v(input logic r, rd, h, im, rdy, sel, vld, input int st, fc);
      vec_t x;
      x.rst = r; x.rd = rd; x.h = h; x.im = im;
      x.rdy = rdy; x.sel = sel; x.vld = vld; x.st = st; x.fc = fc;
      return x;
   endfunction

   vec_t tbl[$];

   initial begin
      // rst rd h im | rdy sel vld st fc
      tbl.push_back(v(1,0,0,1, 0,0,0, 0,0));
      tbl.push_back(v(0,0,0,1, 0,0,0, 0,0));  // START cycle
      tbl.push_back(v(0,0,0,1, 1,0,0, 0,0));
      tbl.push_back(v(0,0,0,1, 1,0,1, 0,0));
      tbl.push_back(v(0,0,1,1, 0,0,1, 0,0));  // hold x3
      tbl.push_back(v(0,0,1,1, 0,0,1, 1,0));
      tbl.push_back(v(0,0,1,1, 0,0,1, 2,0));
      tbl.push_back(v(0,0,0,1, 1,0,1, 3,0));
      tbl.push_back(v(0,1,1,1, 1,1,1, 3,0));  // redirect beats hold
      tbl.push_back(v(0,0,0,1, 1,0,0, 3,1));
      tbl.push_back(v(0,1,0,1, 1,1,1, 3,1));  // back-to-back redirects
      tbl.push_back(v(0,1,0,1, 1,1,0, 3,2));
      tbl.push_back(v(0,0,0,0, 0,0,0, 3,3));  // FLUSH: no stall count
      tbl.push_back(v(0,0,0,0, 0,0,0, 3,3));  // RUN: stall counted
      tbl.push_back(v(0,0,0,1, 1,0,0, 4,3));
      tbl.push_back(v(0,0,0,1, 1,0,1, 4,3));
      tbl.push_back(v(1,1,0,1, 0,0,0, 0,0));  // reset
      tbl.push_back(v(0,1,0,1, 0,0,0, 0,0));  // redirect ignored in START
      tbl.push_back(v(0,0,0,0, 0,0,0, 0,0));
      tbl.push_back(v(0,0,0,1, 1,0,0, 1,0));
      tbl.push_back(v(0,0,0,1, 1,0,1, 1,0));

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].rd, tbl[i].h, tbl[i].im);
         chk($sformatf("vec%0d_ready", i), int'(ctrl.ready_Q100H), int'(tbl[i].rdy));
         chk($sformatf("vec%0d_sel", i), int'(ctrl.sel_next_pc_alu_out_Q102H), int'(tbl[i].sel));
         chk($sformatf("vec%0d_flush", i), int'(flush_Q101H & flush_Q102H), int'(tbl[i].sel));
         chk($sformatf("vec%0d_valid", i), int'(valid_Q101H), int'(tbl[i].vld));
         chk($sformatf("vec%0d_stall_cnt", i), int'(stall_cnt), tbl[i].st);
         chk($sformatf("vec%0d_flush_cnt", i), int'(flush_cnt), tbl[i].fc);
         tick();
      end

      // stall counter saturation with imem_ready low for 20 cycles
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      chk("sat_stall_cnt", int'(stall_cnt), 15);
      tick();

      // reset in FLUSH with stall_cnt at 7
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      chk("pre_flush_stall_cnt", int'(stall_cnt), 7);
      tick();
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      chk("rst_in_flush_outs", int'({ctrl, flush_Q101H, flush_Q102H, valid_Q101H}), 0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b1);
      chk("after_rst_outs", int'({ctrl, flush_Q101H, flush_Q102H, valid_Q101H}), 0);
      chk("after_rst_stall_cnt", int'(stall_cnt), 0);
      chk("after_rst_flush_cnt", int'(flush_cnt), 0);
      tick();

      // random traffic against the model
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 99) < 2)  ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
             ($urandom_range(0, 99) < 80) ? 1'b1 : 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
